// File: rtl/demorgan_tester.sv
// demorgan_tester: drives a two-input gate through the truth table 00, 01, 10, 11,
// samples its output after a programmable settle time and counts mismatches
// against the NOR (De Morgan second-law) expectation over REPEAT sweeps.
// Optional feature macro: DEMORGAN_TESTER_FIRST_LAW_EN adds a law_sel input that
// switches the whole run to the NAND (first-law) expectation.
module demorgan_tester #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned REPEAT = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DEMORGAN_TESTER_FIRST_LAW_EN
  input  logic             law_sel,
`endif
  input  logic             e_i,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam logic [7:0] SettleLd = 8'(SETTLE - 1);
  localparam logic [7:0] RepLast  = 8'(REPEAT - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         sweep_q, sweep_d;
  logic [1:0]         vec_q, vec_d;
  logic               a_q, a_d, b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [3:0]         fv_q, fv_d;
  logic               exp_e;
  logic               mismatch;

`ifdef DEMORGAN_TESTER_FIRST_LAW_EN
  logic               law_q, law_d;
  // Law choice is latched at start so it stays fixed for the whole run.
  assign exp_e = law_q ? ~(a_q & b_q) : ~(a_q | b_q);
`else
  assign exp_e = ~(a_q | b_q);
`endif

  // Next-state and registered-output computation for the sweep FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_d  = sweep_q;
    vec_d    = vec_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    mismatch = 1'b0;
`ifdef DEMORGAN_TESTER_FIRST_LAW_EN
    law_d    = law_q;
`endif
    unique case (state_q)
      StIdle: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          vec_d   = 2'd0;
          sweep_d = 8'd0;
          err_d   = '0;
          fv_d    = 4'd0;
          pass_d  = 1'b0;
          cnt_d   = SettleLd;
          busy_d  = 1'b1;
`ifdef DEMORGAN_TESTER_FIRST_LAW_EN
          law_d   = law_sel;
`endif
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSample: begin
        mismatch = (e_i != exp_e);
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          fv_d[vec_q] = 1'b1;
        end
        if (vec_q == 2'd3 && sweep_q == RepLast) begin
          // pass must reflect the final sample, hence err_d rather than err_q.
          pass_d  = (err_d == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = StDone;
        end else begin
          vec_d = vec_q + 2'd1;
          if (vec_q == 2'd3) begin
            sweep_d = sweep_q + 8'd1;
          end
          {a_d, b_d} = vec_d;
          cnt_d      = SettleLd;
          state_d    = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      sweep_q <= 8'd0;
      vec_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 4'd0;
`ifdef DEMORGAN_TESTER_FIRST_LAW_EN
      law_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sweep_q <= sweep_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
`ifdef DEMORGAN_TESTER_FIRST_LAW_EN
      law_q   <= law_d;
`endif
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: doc/demorgan_tester.md
# demorgan_tester

- Sequential stimulus generator and response checker for the De Morgan second-law gate (e = ~a & ~b, equivalently ~(a | b)).
- It drives the gate's two inputs, samples its output after a programmable settle time and compares it with the expected NOR value.
- It accumulates mismatches over a configurable number of full sweeps of the truth table.
- It sits opposite the gate under test on the lab board, replacing manual switch-and-LED checking.

## Interface
Parameters:
- SETTLE, default 2: cycles each vector is held before sampling; legal range 1..255.
- REPEAT, default 1: number of full 4-vector sweeps per run; legal range 1..255.
- ERR_W, default 8: width of err_count.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- start  input  1  run request; sampled only in IDLE.
- e_i  input  1  output of the gate under test.
- a_o  output  1  gate input a, registered.
- b_o  output  1  gate input b, registered.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  one-cycle pulse marking end of run.
- pass  output  1  high when the last completed run had zero mismatches; held until the next accepted start.
- err_count  output  ERR_W  mismatch count of the current or last run; saturates at all-ones.
- fail_vec  output  4  sticky per-vector fail flags; bit i set when vector i = {a,b} mismatched in any sweep.

## Operation
States: IDLE, SETTLE, SAMPLE, DONE.

- **IDLE**
  - a_o = b_o = 0, busy = 0.
  - start = 1 at a clock edge:
    - clear vec, sweep, err_count and fail_vec;
    - clear pass;
    - load settle counter with SETTLE−1;
    - go to SETTLE.
  - start = 0: stay in IDLE.
- **SETTLE**
  - Drive a_o = vec[1], b_o = vec[0].
  - Decrement the counter each cycle.
  - When the counter is 0, go to SAMPLE.
- **SAMPLE**
  - Expected value = ~a_o & ~b_o.
  - If e_i ≠ expected:
    - err_count += 1, saturating;
    - fail_vec[vec] ← 1.
  - If vec = 3 and sweep = REPEAT−1: go to DONE.
  - Otherwise:
    - vec ← vec + 1, wrapping 3→0;
    - on wrap, sweep += 1;
    - reload the counter with SETTLE−1;
    - go to SETTLE.
- **DONE**
  - done = 1 for exactly one cycle.
  - pass = (err_count = 0); the comparison includes the final sample's result.
  - Go to IDLE unconditionally.
- Vector order is fixed: 00, 01, 10, 11.
- start is ignored while busy. A start held high through DONE is accepted on the first IDLE edge, which gives back-to-back runs.
- Reset values: a_o = 0, b_o = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vec = 0, state = IDLE.
- Reset mid-run aborts immediately. All outputs take their reset values, and done is not pulsed for the aborted run.

## Timing
- Start accepted at edge t0. Vector 0 appears on a_o/b_o and busy goes high in the cycle after t0.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 cycle in SAMPLE.
- e_i is compared at the edge that leaves SAMPLE. The gate therefore gets at least SETTLE+1 cycles of stable input before the compare.
- DONE is entered at edge t0 + 4·REPEAT·(SETTLE+1). done is high during the following cycle.
- busy falls in the same cycle that done rises.
- Back-to-back runs: the minimum start-to-start spacing is 4·REPEAT·(SETTLE+1) + 2 cycles.
- err_count and fail_vec update one cycle after each SAMPLE. They are stable from the done cycle until the next accepted start.

## Configuration
- Macro: DEMORGAN_TESTER_FIRST_LAW_EN.
- When defined:
  - an extra input port `law_sel  input  1` is added;
  - law_sel is sampled with start;
  - law_sel = 1 sets the expected value to ~a_o | ~b_o (first law, NAND) for the whole run;
  - law_sel = 0 selects the NOR check.
- When undefined:
  - no law_sel port exists;
  - the expected value is always ~a_o & ~b_o.

## Test plan
- Correct NOR gate, SETTLE=2, REPEAT=1, start pulse at t0: vectors 00, 01, 10, 11, each held 3 cycles; done at t0+12; pass=1, err_count=0, fail_vec=0000.
- e_i stuck at 0, REPEAT=1: only vector 00 mismatches; err_count=1, fail_vec=0001, pass=0.
- DUT is an OR gate, SETTLE=1, REPEAT=3: every vector mismatches every sweep; err_count=12, fail_vec=1111; done 24 cycles after start.
- ERR_W=2, REPEAT=3 with the OR-gate DUT: err_count saturates at 3, not 12; pass=0.
- start re-pulsed while busy, then rst_n=0 for one cycle mid-sweep:
  - the second start has no effect;
  - after reset all outputs read 0 and no done pulse appears;
  - a new start runs a full clean sweep.
- With DEMORGAN_TESTER_FIRST_LAW_EN defined, NAND DUT:
  - law_sel=1 gives pass=1;
  - law_sel=0 gives err_count=2 and fail_vec=0110 for REPEAT=1.
